pmodclp_ascii_fmt: RTL and testbench
====================================

Name: pmodclp_ascii_fmt

Overview:
- Upstream formatting stage for the PmodCLP LCD driver.
- Converts two unsigned fixed-point readings (units of 0.1, range 00.0–99.9) into the six ASCII digit bytes the driver displays: tens, ones and tenths for each line.
- Uses sequential double-dabble (shift-and-add-3), one channel after the other.
- Both channels' digits are committed together, so the LCD never shows a half-updated pair.

Parameters:
- VAL_W, 10, input value width in bits. Legal range 10..16. Raw value = reading × 10.
- MAX_VAL, 999, largest displayable raw value. Anything above it is over-range.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  request a conversion. Sampled only in IDLE.
- val_1  input  VAL_W  raw value for line 1.
- val_2  input  VAL_W  raw value for line 2.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the new digits are committed.
- ovr_1  output  1  line 1 value exceeded MAX_VAL at the last commit.
- ovr_2  output  1  line 2 value exceeded MAX_VAL at the last commit.
- d10_1, d1_1, d10ths_1  output  8 each  ASCII tens, ones and tenths digits for line 1.
- d10_2, d1_2, d10ths_2  output  8 each  ASCII tens, ones and tenths digits for line 2.

Behaviour:
- Reset (RST_N low, asynchronous):
  - all six digit outputs = 8'h30 ('0');
  - busy = 0, done = 0, ovr_1 = ovr_2 = 0;
  - FSM = IDLE; the iteration counter and staging registers are cleared.
- Reset asserted mid-conversion aborts the conversion. Outputs return to the reset values and no done pulse is produced.
- FSM states: IDLE, SHIFT, STORE.
  - IDLE:
    - start = 1 at a rising edge latches val_1 and val_2 into hold registers.
    - The same edge loads the shift register with channel 0, clears the 12-bit BCD accumulator, sets ch = 0 and moves to SHIFT.
    - busy goes high on that edge.
  - SHIFT:
    - Each cycle, add 3 to any BCD nibble ≥ 5, then shift {BCD, value} left by 1.
    - Runs exactly VAL_W cycles, then moves to STORE.
    - Bits shifted out above the 12-bit accumulator are discarded.
  - STORE, ch = 0:
    - Write ASCII (nibble + 8'h30) of hundreds, tens and units BCD into channel-0 staging registers.
    - Set staged over-range flag = (held value > MAX_VAL).
    - Load channel 1, set ch = 1 and return to SHIFT.
  - STORE, ch = 1:
    - Stage channel 1 the same way.
    - On this same edge, copy both staging sets to the outputs, pulse done high for the following cycle, drop busy and return to IDLE.
- Digit mapping: BCD hundreds → d10_x, tens → d1_x, units → d10ths_x. Example: raw value 457 displays as 45.7.
- Over-range: if held value > MAX_VAL, all three digits of that line = 8'h2D ('-') and ovr_x = 1. Conversion time is unchanged.
- Latency: start sampled at edge E → outputs and done valid after edge E + 2·VAL_W + 2. This is E + 22 at the default width.
- Constant latency: conversion time is independent of the input values.
- start while busy is ignored. It is not queued.
- start held high continuously: a new conversion begins at the edge after done. Back-to-back periodic updates are legal.
- val_1 and val_2 may change freely after the start edge; only the values held at the start edge are converted.
- Outputs are stable and hold their last committed values between commits.

Optional Feature:
- Macro: PMODCLP_LEAD_BLANK_EN.
- Defined: when a non-over-range line's tens digit is 0, d10_x = 8'h20 (space) instead of 8'h30. Ones and tenths digits are never blanked.
- Not defined: the tens digit is always shown as an ASCII digit, including '0'.
- Reset values are 8'h30 in both builds.

Test Plan:
- Basic conversion: reset, start pulse with val_1 = 123, val_2 = 456 → after 22 cycles done = 1 for one cycle. d10_1/d1_1/d10ths_1 = 31/32/33, d10_2/d1_2/d10ths_2 = 34/35/36, ovr_1 = ovr_2 = 0, busy falls on the same edge.
- Limits and over-range: val_1 = 999, val_2 = 1000 → line 1 = 39/39/39 with ovr_1 = 0; line 2 = 2D/2D/2D with ovr_2 = 1.
- Leading zero: val_1 = 5, val_2 = 0 → line 1 = 30/30/35 and line 2 = 30/30/30 without the macro; line 1 = 20/30/35 and line 2 = 20/30/30 with PMODCLP_LEAD_BLANK_EN.
- Busy and input handling: start again and change val_1 at cycle 5 of a conversion → second start ignored, exactly one done pulse, outputs reflect the originally latched values. Then hold start high → a second conversion completes 22 cycles after the first done.
- Reset mid-operation: assert RST_N low at cycle 12 of a conversion → all digits 8'h30, busy = 0, no done pulse. After release, a fresh start with values 250/71 → line 1 = 32/35/30, line 2 = 30/37/31.

Source files
------------

// File: rtl/pmodclp_ascii_fmt.sv
`default_nettype none
// ============================================================================
// Module      : pmodclp_ascii_fmt
// Description : Formats two raw fixed-point readings (0.1 units, 00.0-99.9)
//               into ASCII tens/ones/tenths bytes for the PmodCLP LCD driver.
//               Sequential double-dabble, channel 0 then channel 1; both
//               lines are committed to the outputs on the same edge.
//               Optional macro PMODCLP_LEAD_BLANK_EN: a tens digit of zero
//               on a non-over-range line is shown as a space.
// Revision    : 1.0 - initial release
// ============================================================================
module pmodclp_ascii_fmt #(
  parameter int          VAL_W   = 10,
  parameter int unsigned MAX_VAL = 999
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [VAL_W-1:0] val_1,
  input  logic [VAL_W-1:0] val_2,
  output logic             busy,
  output logic             done,
  output logic             ovr_1,
  output logic             ovr_2,
  output logic [7:0]       d10_1,
  output logic [7:0]       d1_1,
  output logic [7:0]       d10ths_1,
  output logic [7:0]       d10_2,
  output logic [7:0]       d1_2,
  output logic [7:0]       d10ths_2
);

  localparam int             SR_W       = 12 + VAL_W;
  localparam logic [4:0]     C_CNT_LAST = 5'(VAL_W - 1);
  localparam logic [23:0]    C_LINE_RST = {3{8'h30}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_STORE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              ch_q, ch_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [VAL_W-1:0]  hold_1_q, hold_1_d;
  logic [VAL_W-1:0]  hold_2_q, hold_2_d;
  logic [23:0]       stg_line_q, stg_line_d;
  logic              stg_ovr_q, stg_ovr_d;
  logic [23:0]       line_1_q, line_1_d;
  logic [23:0]       line_2_q, line_2_d;
  logic              ovr_1_q, ovr_1_d;
  logic              ovr_2_q, ovr_2_d;
  logic              done_q, done_d;

  logic [SR_W-1:0]   w_adj;
  logic [11:0]       w_bcd;
  logic              w_ovr_cur;
  logic [23:0]       w_line_cur;

  // Single BCD nibble to its ASCII digit.
  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  // Three display bytes for one line; over-range lines show dashes.
  function automatic logic [23:0] fmt_line(input logic [11:0] bcd, input logic ovr);
    logic [7:0] tens;
    tens = to_ascii(bcd[11:8]);
`ifdef PMODCLP_LEAD_BLANK_EN
    if (bcd[11:8] == 4'h0) begin
      tens = 8'h20;
    end
`else
`endif
    if (ovr) begin
      return {3{8'h2D}};
    end
    return {tens, to_ascii(bcd[7:4]), to_ascii(bcd[3:0])};
  endfunction

  // Add-3 correction on every BCD nibble that is 5 or more before the shift.
  always_comb begin
    w_adj = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (sr_q[VAL_W+4*i +: 4] >= 4'd5) begin
        w_adj[VAL_W+4*i +: 4] = sr_q[VAL_W+4*i +: 4] + 4'd3;
      end
    end
  end

  // Formatted result of the channel currently sitting in the accumulator.
  always_comb begin
    w_bcd      = sr_q[SR_W-1 -: 12];
    w_ovr_cur  = ch_q ? (32'(hold_2_q) > MAX_VAL) : (32'(hold_1_q) > MAX_VAL);
    w_line_cur = fmt_line(w_bcd, w_ovr_cur);
  end

  // Next-state and datapath control for the IDLE/SHIFT/STORE sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    sr_d       = sr_q;
    hold_1_d   = hold_1_q;
    hold_2_d   = hold_2_q;
    stg_line_d = stg_line_q;
    stg_ovr_d  = stg_ovr_q;
    line_1_d   = line_1_q;
    line_2_d   = line_2_q;
    ovr_1_d    = ovr_1_q;
    ovr_2_d    = ovr_2_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hold_1_d = val_1;
          hold_2_d = val_2;
          sr_d     = {12'h000, val_1};
          cnt_d    = 5'd0;
          ch_d     = 1'b0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Bits pushed above the 12-bit accumulator simply fall off.
        sr_d  = w_adj << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == C_CNT_LAST) begin
          cnt_d   = 5'd0;
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        if (!ch_q) begin
          stg_line_d = w_line_cur;
          stg_ovr_d  = w_ovr_cur;
          sr_d       = {12'h000, hold_2_q};
          ch_d       = 1'b1;
          state_d    = S_SHIFT;
        end else begin
          // Channel 1 goes straight to the outputs alongside the staged
          // channel 0 so both lines change on the same edge.
          line_1_d = stg_line_q;
          ovr_1_d  = stg_ovr_q;
          line_2_d = w_line_cur;
          ovr_2_d  = w_ovr_cur;
          done_d   = 1'b1;
          ch_d     = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      ch_q       <= 1'b0;
      sr_q       <= '0;
      hold_1_q   <= '0;
      hold_2_q   <= '0;
      stg_line_q <= C_LINE_RST;
      stg_ovr_q  <= 1'b0;
      line_1_q   <= C_LINE_RST;
      line_2_q   <= C_LINE_RST;
      ovr_1_q    <= 1'b0;
      ovr_2_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      sr_q       <= sr_d;
      hold_1_q   <= hold_1_d;
      hold_2_q   <= hold_2_d;
      stg_line_q <= stg_line_d;
      stg_ovr_q  <= stg_ovr_d;
      line_1_q   <= line_1_d;
      line_2_q   <= line_2_d;
      ovr_1_q    <= ovr_1_d;
      ovr_2_q    <= ovr_2_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign ovr_1    = ovr_1_q;
  assign ovr_2    = ovr_2_q;
  assign d10_1    = line_1_q[23:16];
  assign d1_1     = line_1_q[15:8];
  assign d10ths_1 = line_1_q[7:0];
  assign d10_2    = line_2_q[23:16];
  assign d1_2     = line_2_q[15:8];
  assign d10ths_2 = line_2_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_pmodclp_ascii_fmt.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmodclp_ascii_fmt
// Description : Directed self-checking bench for pmodclp_ascii_fmt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmodclp_ascii_fmt;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       start = 1'b0;
  logic [9:0] val_1 = '0;
  logic [9:0] val_2 = '0;
  logic       busy, done, ovr_1, ovr_2;
  logic [7:0] d10_1, d1_1, d10ths_1, d10_2, d1_2, d10ths_2;
  logic [23:0] line_1, line_2;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PMODCLP_LEAD_BLANK_EN
  localparam logic [7:0] LZ = 8'h20;
`else
  localparam logic [7:0] LZ = 8'h30;
`endif

  pmodclp_ascii_fmt dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .val_1    (val_1),
    .val_2    (val_2),
    .busy     (busy),
    .done     (done),
    .ovr_1    (ovr_1),
    .ovr_2    (ovr_2),
    .d10_1    (d10_1),
    .d1_1     (d1_1),
    .d10ths_1 (d10ths_1),
    .d10_2    (d10_2),
    .d1_2     (d1_2),
    .d10ths_2 (d10ths_2)
  );

  always #5 CLK = ~CLK;

  assign line_1 = {d10_1, d1_1, d10ths_1};
  assign line_2 = {d10_2, d1_2, d10ths_2};

  // One-cycle start pulse; returns at the falling edge just after the start edge.
  task automatic pulse_start(input logic [9:0] a, input logic [9:0] b);
    @(negedge CLK);
    val_1 = a;
    val_2 = b;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Counts rising edges from the start edge until done is seen (bounded).
  task automatic wait_done(output int lat, output logic busy_before);
    lat = 0;
    busy_before = busy;
    while (!done && lat < 60) begin
      busy_before = busy;
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_checks++;
    if (line_1 !== 24'h303030 || line_2 !== 24'h303030) begin
      n_fail++;
      $display("FAIL reset_digits: got %h/%h expected 303030/303030", line_1, line_2);
    end
    n_checks++;
    if ({busy, done, ovr_1, ovr_2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, ovr_1, ovr_2});
    end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    int lat;
    logic bb;
    pulse_start(10'd123, 10'd456);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_rise: got %b expected 1", busy);
    end
    wait_done(lat, bb);
    n_checks++;
    if (lat !== 22) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected 22", lat);
    end
    n_checks++;
    if (bb !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_fall: got before=%b at_done=%b expected 1/0", bb, busy);
    end
    n_checks++;
    if (line_1 !== 24'h313233 || line_2 !== 24'h343536) begin
      n_fail++;
      $display("FAIL basic_digits: got %h/%h expected 313233/343536", line_1, line_2);
    end
    n_checks++;
    if ({ovr_1, ovr_2} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_ovr: got %b expected 00", {ovr_1, ovr_2});
    end
    @(negedge CLK);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_width: got %b expected 0", done);
    end
  endtask

  task automatic test_limits();
    int lat;
    logic bb;
    pulse_start(10'd999, 10'd1000);
    wait_done(lat, bb);
    n_checks++;
    if (lat !== 22) begin
      n_fail++;
      $display("FAIL limits_latency: got %0d expected 22", lat);
    end
    n_checks++;
    if (line_1 !== 24'h393939 || line_2 !== 24'h2D2D2D) begin
      n_fail++;
      $display("FAIL limits_digits: got %h/%h expected 393939/2d2d2d", line_1, line_2);
    end
    n_checks++;
    if ({ovr_1, ovr_2} !== 2'b01) begin
      n_fail++;
      $display("FAIL limits_ovr: got %b expected 01", {ovr_1, ovr_2});
    end
  endtask

  task automatic test_lead_zero();
    int lat;
    logic bb;
    pulse_start(10'd5, 10'd0);
    wait_done(lat, bb);
    n_checks++;
    if (line_1 !== {LZ, 16'h3035} || line_2 !== {LZ, 16'h3030}) begin
      n_fail++;
      $display("FAIL lead_zero_digits: got %h/%h expected %h/%h",
               line_1, line_2, {LZ, 16'h3035}, {LZ, 16'h3030});
    end
    n_checks++;
    if ({ovr_1, ovr_2} !== 2'b00) begin
      n_fail++;
      $display("FAIL lead_zero_ovr: got %b expected 00", {ovr_1, ovr_2});
    end
  endtask

  task automatic test_busy_inputs();
    int ndone;
    int first;
    ndone = 0;
    first = 0;
    pulse_start(10'd300, 10'd42);
    repeat (4) @(negedge CLK);
    // Second request and new values land on the fifth edge of the conversion.
    start = 1'b1;
    val_1 = 10'd999;
    val_2 = 10'd1000;
    @(negedge CLK);
    start = 1'b0;
    for (int k = 6; k <= 50; k++) begin
      @(negedge CLK);
      if (done) begin
        ndone++;
        if (first == 0) first = k;
      end
    end
    n_checks++;
    if (ndone !== 1 || first !== 22) begin
      n_fail++;
      $display("FAIL busy_ignore: got pulses=%0d first=%0d expected 1/22", ndone, first);
    end
    n_checks++;
    if (line_1 !== 24'h333030 || line_2 !== {LZ, 16'h3432}) begin
      n_fail++;
      $display("FAIL busy_latched_vals: got %h/%h expected 333030/%h",
               line_1, line_2, {LZ, 16'h3432});
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    logic bb;
    @(negedge CLK);
    val_1 = 10'd123;
    val_2 = 10'd456;
    start = 1'b1;
    @(negedge CLK);
    wait_done(lat, bb);
    n_checks++;
    if (lat !== 22 || line_1 !== 24'h313233 || line_2 !== 24'h343536) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d %h/%h expected 22 313233/343536",
               lat, line_1, line_2);
    end
    // These values are taken by the restart on the edge that ends done.
    val_1 = 10'd777;
    val_2 = 10'd88;
    gap = 0;
    do begin
      @(negedge CLK);
      gap++;
    end while (!done && gap < 60);
    start = 1'b0;
    n_checks++;
    if (gap !== 23) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d expected 23", gap);
    end
    n_checks++;
    if (line_1 !== 24'h373737 || line_2 !== {LZ, 16'h3838}) begin
      n_fail++;
      $display("FAIL b2b_second: got %h/%h expected 373737/%h", line_1, line_2, {LZ, 16'h3838});
    end
    @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic bb;
    int seen_done;
    int seen_busy;
    seen_done = 0;
    seen_busy = 0;
    pulse_start(10'd123, 10'd456);
    repeat (11) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    n_checks++;
    if (line_1 !== 24'h303030 || line_2 !== 24'h303030 ||
        {busy, done, ovr_1, ovr_2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %h/%h flags=%b expected 303030/303030 0000",
               line_1, line_2, {busy, done, ovr_1, ovr_2});
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    n_checks++;
    if (seen_done !== 0 || seen_busy !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got done=%0d busy=%0d expected 0/0", seen_done, seen_busy);
    end
    pulse_start(10'd250, 10'd71);
    wait_done(lat, bb);
    n_checks++;
    if (lat !== 22 || line_1 !== 24'h323530 || line_2 !== {LZ, 16'h3731}) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: got lat=%0d %h/%h expected 22 323530/%h",
               lat, line_1, line_2, {LZ, 16'h3731});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limits();
    test_lead_zero();
    test_busy_inputs();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
